div5_seq: RTL

Sequential restoring unsigned divider, the inverse operation of the team's 5-bit array multiplier. It takes a W-bit dividend and divisor under a start/done handshake and returns a W-bit quotient and remainder after W iterations. It also flags divide-by-zero. The block sits beside the multiplier in the arithmetic lab datapath and is the first arithmetic block there with state.

---
 rtl/div5_pkg.sv | 19 +
 rtl/div5_step.sv | 23 ++
 rtl/div5_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/div5_pkg.sv
// Shared types and constants for the div5_seq sequential divider.
package div5_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIV5_W = 5;

  function automatic int clog2(input int n);
    int v;
    v = 0;
    while ((1 << v) < n) v++;
    return v;
  endfunction

endpackage

// File: rtl/div5_step.sv
// One restoring-division stage: shift in a bit, trial-subtract, keep or restore.
module div5_step
  import div5_pkg::*;
#(
  parameter int W = DIV5_W
) (
  input  logic [W:0]   r,
  input  logic         in_bit,
  input  logic [W-1:0] divisor,
  output logic [W:0]   r_next,
  output logic         q_bit
);

  logic [W+1:0] sh;
  logic [W+1:0] diff;

  // One spare MSB so the borrow of the trial subtraction is visible as the sign.
  assign sh     = {r, in_bit};
  assign diff   = sh - {2'b00, divisor};
  assign q_bit  = ~diff[W+1];
  assign r_next = q_bit ? diff[W:0] : sh[W:0];

endmodule

// File: rtl/div5_seq.sv
// Sequential restoring unsigned divider with start/done handshake and divide-by-zero flag.
// Optional macro DIV5_DZ_FAST_EN: a zero divisor skips the iterations and completes early.
module div5_seq
  import div5_pkg::*;
#(
  parameter int W = DIV5_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quo,
  output logic [W-1:0] rem,
  output logic         dz
);

  localparam int CW = clog2(W + 1);

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W:0]     r_q, r_d;
  logic [W-1:0]   q_q, q_d;
  logic [W-1:0]   dvs_q, dvs_d;
  logic [W-1:0]   quo_q, quo_d;
  logic [W-1:0]   rem_q, rem_d;
  logic           dz_q, dz_d;
  logic [W:0]     r_nxt;
  logic           q_bit;

  div5_step #(.W(W)) u_step (
    .r       (r_q),
    .in_bit  (q_q[W-1]),
    .divisor (dvs_q),
    .r_next  (r_nxt),
    .q_bit   (q_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          q_d     = dividend;
          dvs_d   = divisor;
          r_d     = '0;
          cnt_d   = CW'(W);
`ifdef DIV5_DZ_FAST_EN
          if (divisor == '0) cnt_d = '0;
`endif
        end
      end
      RUN: begin
        // cnt counts remaining iterations; the cnt==0 cycle publishes the result.
        if (cnt_q != '0) begin
          r_d   = r_nxt;
          q_d   = {q_q[W-2:0], q_bit};
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = DONE;
          quo_d   = q_q;
          rem_d   = r_q[W-1:0];
          dz_d    = (dvs_q == '0);
`ifdef DIV5_DZ_FAST_EN
          if (dvs_q == '0) begin
            quo_d = '1;
            rem_d = q_q;
          end
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign quo  = quo_q;
  assign rem  = rem_q;
  assign dz   = dz_q;

endmodule
